// File: rtl/parity_pkg.sv
// Constants shared by the serial parity generator and checker:
// FSM state encoding and parity-mode selectors.
package parity_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/parity_checker.sv
// Serial frame receiver: DATA_W data bits MSB first, then one parity bit.
// Presents the byte, a parity error flag, a one-cycle strobe and an error count.
module parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              asyn_rst,
  input  logic              valid_in,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              valid_out,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LastData = CW'(DATA_W - 1);
  localparam logic        ExpParity = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [DATA_W-1:0] r_data_out;
  logic              r_parity_err;
  logic              r_valid_out;

  logic [DATA_W:0]   w_shift_wide;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_err;
  logic              w_err_inc;

  // Widening first keeps the shift legal when DATA_W is 1.
  assign w_shift_wide = {r_shift, data_in};
  assign w_shift_nxt  = w_shift_wide[DATA_W-1:0];
  assign w_err        = ((r_par ^ data_in) != ExpParity);
  assign w_err_inc    = valid_in && (r_state == ST_PAR) && w_err;

  always_ff @(posedge clk) begin
    if (asyn_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_data_out   <= '0;
      r_parity_err <= 1'b0;
      r_valid_out  <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      if (valid_in) begin
        case (r_state)
          ST_IDLE: begin
            r_shift <= w_shift_nxt;
            r_par   <= data_in;
            r_cnt   <= CW'(1);
            r_state <= (DATA_W == 1) ? ST_PAR : ST_DATA;
          end
          ST_DATA: begin
            r_shift <= w_shift_nxt;
            r_par   <= r_par ^ data_in;
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == LastData) r_state <= ST_PAR;
          end
          ST_PAR: begin
            r_data_out   <= r_shift;
            r_parity_err <= w_err;
            r_valid_out  <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_IDLE;
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .i_clk   (clk),
    .i_rst   (asyn_rst),
    .i_inc   (w_err_inc),
    .o_count (err_count)
  );

  assign data_out   = r_data_out;
  assign parity_err = r_parity_err;
  assign valid_out  = r_valid_out;
  assign busy       = (r_state != ST_IDLE);

endmodule
